// File: rtl/rv32_div.sv
// RV32M divide unit: DIV/DIVU/REM/REMU by restoring division,
// one quotient bit per cycle, valid/ready on both sides.
module rv32_div #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [1:0]      div_op,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t          state;
   logic            rem_op;
   logic            neg_q;
   logic            neg_r;
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] dvsr;
   logic [CW-1:0]   count;

   logic            is_signed;
   logic            a_neg;
   logic            b_neg;
   logic            div_zero;
   logic            ovf;
   logic [XLEN-1:0] abs_a;
   logic [XLEN-1:0] abs_b;
   logic [XLEN-1:0] special;
   logic [XLEN:0]   rem_sh;
   logic            ge;
   logic [XLEN-1:0] trial;
   logic [XLEN-1:0] rem_nx;
   logic [XLEN-1:0] quo_nx;
   logic [XLEN-1:0] res_fix;

   always_comb begin
      is_signed = ~div_op[0];
      a_neg     = is_signed & operand_a[XLEN-1];
      b_neg     = is_signed & operand_b[XLEN-1];
      abs_a     = a_neg ? -operand_a : operand_a;
      abs_b     = b_neg ? -operand_b : operand_b;
      div_zero  = (operand_b == '0);
      ovf       = is_signed
                & (operand_a == {1'b1, {(XLEN-1){1'b0}}})
                & (operand_b == '1);
      // results that never need the iterative datapath
      if (div_zero)
         special = div_op[1] ? operand_a : '1;
      else
         special = div_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end

   // rem is always < dvsr, so the shifted value needs one extra bit
   always_comb begin
      rem_sh = {rem, quo[XLEN-1]};
      ge     = (rem_sh >= {1'b0, dvsr});
      trial  = rem_sh[XLEN-1:0] - dvsr;
      if (ge) begin
         rem_nx = trial;
         quo_nx = {quo[XLEN-2:0], 1'b1};
      end else begin
         rem_nx = rem_sh[XLEN-1:0];
         quo_nx = {quo[XLEN-2:0], 1'b0};
      end
      if (rem_op)
         res_fix = neg_r ? -rem_nx : rem_nx;
      else
         res_fix = neg_q ? -quo_nx : quo_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         busy      <= 1'b0;
         result    <= '0;
         rem_op    <= 1'b0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         rem       <= '0;
         quo       <= '0;
         dvsr      <= '0;
         count     <= '0;
      end else if (flush) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  rem_op    <= div_op[1];
                  neg_q     <= a_neg ^ b_neg;
                  neg_r     <= a_neg;
                  quo       <= abs_a;
                  dvsr      <= abs_b;
                  rem       <= '0;
                  count     <= '0;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (div_zero || ovf) begin
                     result    <= special;
                     rsp_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               rem   <= rem_nx;
               quo   <= quo_nx;
               count <= count + CW'(1);
               if (count == CW'(XLEN-1)) begin
                  result    <= res_fix;
                  rsp_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32_div.sv
// Bench for rv32_div: directed vectors plus a transaction-level
// reference model checked against the outputs every cycle.
module tb_rv32_div;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  div_op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] result;
   logic        busy;

   int checks = 0;
   int errors = 0;

   rv32_div #(.XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .div_op    (div_op),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .result    (result),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // RISC-V M semantics via wide integer arithmetic
   function automatic logic [31:0] model(input logic [1:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      if (b == 32'd0)
         return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0]) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return op[1] ? 32'(sa % sb) : 32'(sa / sb);
      end
      ua = {32'd0, a};
      ub = {32'd0, b};
      return op[1] ? 32'(ua % ub) : 32'(ua / ub);
   endfunction

   function automatic bit is_special(input logic [1:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
      return (b == 32'd0) ||
             (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   bit          armed = 0;
   bit          pending = 0;
   bit          seen = 0;
   bit          after_rst = 0;
   int          lat = 0;
   int          exp_lat = 0;
   logic [31:0] exp_res = '0;

   always @(negedge clk) begin
      if (armed) begin
         if (pending) begin
            lat++;
            chk("busy_active", 32'(busy), 32'd1);
            chk("req_ready_active", 32'(req_ready), 32'd0);
            if (rsp_valid) begin
               if (!seen) begin
                  chk("latency", lat, exp_lat);
                  seen = 1;
               end
               chk("result", result, exp_res);
            end else if (lat >= exp_lat) begin
               chk("rsp_valid_late", 32'(rsp_valid), 32'd1);
            end
         end else begin
            chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("idle_req_ready", 32'(req_ready), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
            if (after_rst)
               chk("reset_result", result, 32'd0);
         end
      end
      if (rst) begin
         armed     = 1;
         pending   = 0;
         after_rst = 1;
      end else if (!armed) begin
         pending = 0;
      end else if (flush) begin
         pending = 0;
      end else if (pending) begin
         if (rsp_valid && rsp_ready)
            pending = 0;
      end else if (req_valid) begin
         pending   = 1;
         seen      = 0;
         lat       = 0;
         after_rst = 0;
         exp_res   = model(div_op, operand_a, operand_b);
         exp_lat   = is_special(div_op, operand_a, operand_b) ? 1 : 33;
      end
   end

   task automatic issue(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      bit acc;
      req_valid = 1'b1;
      div_op    = op;
      operand_a = a;
      operand_b = b;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         acc = req_ready && !flush && !rst;
         @(posedge clk);
         #1;
         if (acc) begin
            req_valid = 1'b0;
            operand_a = $urandom;
            operand_b = $urandom;
            div_op    = 2'($urandom);
            return;
         end
      end
      req_valid = 1'b0;
      chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_rsp(output logic [31:0] got, output int n);
      got = '0;
      n   = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            got = result;
            n   = i;
            return;
         end
      end
      chk("rsp_timeout", 32'd0, 32'd1);
   endtask

   task automatic run(input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] lit,
                      input int lit_lat, input string nm);
      logic [31:0] got;
      int          n;
      issue(op, a, b);
      wait_rsp(got, n);
      chk(nm, got, lit);
      chk({nm, "_lat"}, n, lit_lat);
      @(posedge clk);
      #1;
   endtask

   localparam logic [1:0] DIV  = 2'b00;
   localparam logic [1:0] DIVU = 2'b01;
   localparam logic [1:0] REM  = 2'b10;
   localparam logic [1:0] REMU = 2'b11;

   initial begin
      logic [31:0] got;
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      int          n;
      int          sel;

      rst       = 1'b1;
      flush     = 1'b0;
      req_valid = 1'b0;
      div_op    = 2'b00;
      operand_a = '0;
      operand_b = '0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_result", result, 32'd0);
      @(posedge clk);
      #1;

      run(DIVU, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
      run(REMU, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
      run(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
      run(REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
      run(REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, "rem_7_m2");
      run(DIV, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, "div_by0");
      run(DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
      run(REM, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, "rem_by0");
      run(REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, "remu_by0");
      run(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
      run(REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
      run(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, "divu_no_ovf");

      // backpressure with a competing request held high
      rsp_ready = 1'b0;
      issue(DIVU, 32'd1000, 32'd10);
      wait_rsp(got, n);
      chk("bp_first", got, 32'd100);
      repeat (10) begin
         @(posedge clk);
         #1;
         req_valid = 1'b1;
         div_op    = DIVU;
         operand_a = 32'd55;
         operand_b = 32'd5;
      end
      @(negedge clk);
      chk("bp_hold_result", result, 32'd100);
      chk("bp_hold_req_ready", 32'(req_ready), 32'd0);
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bp_release_ready", 32'(req_ready), 32'd1);
      chk("bp_release_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      #1;

      // abort by flush part way through
      issue(DIVU, 32'hDEAD_BEEF, 32'd3);
      repeat (14) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_idle", 32'(req_ready), 32'd1);
      chk("flush_valid", 32'(rsp_valid), 32'd0);
      repeat (40) @(posedge clk);
      #1;
      run(DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, "after_flush");

      // request alongside flush is dropped
      req_valid = 1'b1;
      flush     = 1'b1;
      div_op    = DIVU;
      operand_a = 32'd9;
      operand_b = 32'd3;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      flush     = 1'b0;
      @(negedge clk);
      chk("flush_req_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;

      // abort by reset part way through
      issue(DIV, 32'h7654_3210, 32'hFFFF_FF00);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_result", result, 32'd0);
      chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
      chk("rst_mid_ready", 32'(req_ready), 32'd1);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;

      // back-to-back random traffic
      for (int i = 0; i < 1000; i++) begin
         op  = 2'($urandom);
         a   = $urandom;
         sel = $urandom_range(0, 15);
         if (sel == 0)
            b = 32'd0;
         else if (sel < 5)
            b = 32'($urandom_range(1, 255));
         else if (sel == 5)
            b = 32'hFFFF_FFFF;
         else if (sel == 6) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end else
            b = $urandom;
         issue(op, a, b);
         wait_rsp(got, n);
         @(posedge clk);
         #1;
      end

      repeat (5) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
